// File: rtl/motor_cmd_pkg.sv
// Shared types and helpers for the motor command parser: FSM states, sync
// default, packet byte type and the symmetric speed clamp.
package motor_cmd_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SPD_A = 2'd1,
        SPD_B = 2'd2,
        CHK   = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef logic [7:0] pkt_byte_t;

    // -128 has no positive twin, so pull it in to -127 for the driver.
    function automatic pkt_byte_t clamp_speed(input pkt_byte_t v);
        return (v == 8'h80) ? 8'h81 : v;
    endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and emits a one-cycle
// expired pulse when the count reaches BYTE_TIMEOUT-1; never wraps.
module byte_gap_timer #(
    parameter int BYTE_TIMEOUT = 16000
) (
    input  logic clk_16mhz,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(BYTE_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(BYTE_TIMEOUT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        // An arriving byte masks expiry in the same cycle.
        expired = enable && !clear && (count_q == LAST);
        count_d = count_q;
        if (!enable || clear || expired) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/motor_cmd_parser.sv
// Frames UART bytes into motor speed packets and drives registered speeds,
// a keep-alive toggle and a packet counter. Checksum byte: MOTOR_CMD_CHECKSUM_EN.
module motor_cmd_parser
    import motor_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         BYTE_TIMEOUT = 16000
) (
    input  logic              clk_16mhz,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic signed [7:0] speedA,
    output logic signed [7:0] speedB,
    output logic              aliveStrobe,
    output logic              pkt_err,
    output logic [7:0]        pkt_count
);

    state_e    state_q, state_d;
    pkt_byte_t a_q, a_d;
    pkt_byte_t speed_a_q, speed_a_d;
    pkt_byte_t speed_b_q, speed_b_d;
    logic      alive_q, alive_d;
    logic      pkt_err_q, pkt_err_d;
    logic [7:0] pkt_count_q, pkt_count_d;
    logic      commit;
    pkt_byte_t commit_b;
    logic      gap_expired;
`ifdef MOTOR_CMD_CHECKSUM_EN
    pkt_byte_t b_q, b_d;
`endif

    byte_gap_timer #(
        .BYTE_TIMEOUT(BYTE_TIMEOUT)
    ) u_gap_timer (
        .clk_16mhz(clk_16mhz),
        .rst      (rst),
        .enable   (state_q != HUNT),
        .clear    (rx_valid),
        .expired  (gap_expired)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        speed_a_d   = speed_a_q;
        speed_b_d   = speed_b_q;
        alive_d     = alive_q;
        pkt_count_d = pkt_count_q;
        pkt_err_d   = 1'b0;
        commit      = 1'b0;
        commit_b    = rx_data;
`ifdef MOTOR_CMD_CHECKSUM_EN
        b_d         = b_q;
`endif
        if (rx_valid) begin
            case (state_q)
                HUNT: begin
                    if (rx_data == SYNC_BYTE) state_d = SPD_A;
                end
                SPD_A: begin
                    a_d     = rx_data;
                    state_d = SPD_B;
                end
                SPD_B: begin
`ifdef MOTOR_CMD_CHECKSUM_EN
                    b_d     = rx_data;
                    state_d = CHK;
`else
                    commit   = 1'b1;
                    commit_b = rx_data;
                    state_d  = HUNT;
`endif
                end
`ifdef MOTOR_CMD_CHECKSUM_EN
                CHK: begin
                    commit_b = b_q;
                    if (rx_data == (SYNC_BYTE ^ a_q ^ b_q)) begin
                        commit = 1'b1;
                    end else begin
                        pkt_err_d = 1'b1;
                    end
                    state_d = HUNT;
                end
`endif
                default: state_d = HUNT;
            endcase
        end else if (gap_expired) begin
            // Partial packet is dropped; outputs hold their last command.
            state_d   = HUNT;
            pkt_err_d = 1'b1;
        end

        if (commit) begin
            speed_a_d   = clamp_speed(a_q);
            speed_b_d   = clamp_speed(commit_b);
            alive_d     = ~alive_q;
            pkt_count_d = pkt_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            state_q     <= HUNT;
            a_q         <= '0;
            speed_a_q   <= '0;
            speed_b_q   <= '0;
            alive_q     <= 1'b0;
            pkt_err_q   <= 1'b0;
            pkt_count_q <= '0;
`ifdef MOTOR_CMD_CHECKSUM_EN
            b_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            speed_a_q   <= speed_a_d;
            speed_b_q   <= speed_b_d;
            alive_q     <= alive_d;
            pkt_err_q   <= pkt_err_d;
            pkt_count_q <= pkt_count_d;
`ifdef MOTOR_CMD_CHECKSUM_EN
            b_q         <= b_d;
`endif
        end
    end

    assign speedA      = $signed(speed_a_q);
    assign speedB      = $signed(speed_b_q);
    assign aliveStrobe = alive_q;
    assign pkt_err     = pkt_err_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_motor_cmd_parser.sv
// Directed self-checking bench for motor_cmd_parser; adapts packet length to
// MOTOR_CMD_CHECKSUM_EN.
module tb_motor_cmd_parser;

`ifdef MOTOR_CMD_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk_16mhz = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic signed [7:0] speedA, speedB;
    logic              aliveStrobe, pkt_err;
    logic [7:0]        pkt_count;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_a = 8'h00, exp_b = 8'h00, exp_cnt = 8'h00;
    logic       exp_alive = 1'b0;

    motor_cmd_parser #(
        .SYNC_BYTE(8'hA5),
        .BYTE_TIMEOUT(16000)
    ) dut (
        .clk_16mhz  (clk_16mhz),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .speedA     (speedA),
        .speedB     (speedB),
        .aliveStrobe(aliveStrobe),
        .pkt_err    (pkt_err),
        .pkt_count  (pkt_count)
    );

    always #31 clk_16mhz = ~clk_16mhz;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_err);
        check({tag, ".speedA"}, speedA, exp_a);
        check({tag, ".speedB"}, speedB, exp_b);
        check({tag, ".alive"}, {7'd0, aliveStrobe}, {7'd0, exp_alive});
        check({tag, ".count"}, pkt_count, exp_cnt);
        check({tag, ".err"}, {7'd0, pkt_err}, {7'd0, exp_err});
        $display("txn %s: speedA=%h speedB=%h alive=%b count=%0d err=%b",
                 tag, speedA, speedB, aliveStrobe, pkt_count, pkt_err);
    endtask

    // Drive one byte for one cycle; returns just after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk_16mhz);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_16mhz);
        #1;
    endtask

    function automatic logic [7:0] clamp(input logic [7:0] v);
        return (v == 8'h80) ? 8'h81 : v;
    endfunction

    // Sends SYNC A B [CHK] back-to-back and checks the result one cycle later.
    task automatic send_pkt(input string tag, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] chk);
        logic good;
        good = !CHK_EN || (chk == (8'hA5 ^ a ^ b));
        send_byte(8'hA5);
        send_byte(a);
        send_byte(b);
        if (CHK_EN) send_byte(chk);
        if (good) begin
            exp_a     = clamp(a);
            exp_b     = clamp(b);
            exp_alive = ~exp_alive;
            exp_cnt   = exp_cnt + 8'd1;
        end
        check_outputs(tag, !good);
        idle(1);
        check({tag, ".err_clear"}, {7'd0, pkt_err}, 8'h00);
    endtask

    initial begin
        idle(3);
        check_outputs("reset", 1'b0);
        rst = 1'b0;
        idle(1);

        send_pkt("pkt_pos_neg", 8'h40, 8'hC0, 8'h25);
        check("pkt_pos_neg.speedA_val", speedA, 8'd64);
        send_pkt("pkt_bad_chk", 8'h10, 8'h20, 8'h00);
        send_pkt("pkt_clamp", 8'h80, 8'h7F, 8'h5A);
        check("pkt_clamp.speedA_val", speedA, 8'h81);

        // Timeout: 16000 idle cycles after a partial packet.
        send_byte(8'hA5);
        send_byte(8'h10);
        idle(15999);
        check("timeout.err_early", {7'd0, pkt_err}, 8'h00);
        idle(1);
        check("timeout.err_pulse", {7'd0, pkt_err}, 8'h01);
        send_byte(8'h20);
        check_outputs("timeout.stray", 1'b0);
        idle(4);
        check_outputs("timeout.settled", 1'b0);

        // Byte arriving exactly in the expiry cycle wins.
        send_byte(8'hA5);
        idle(15999);
        send_byte(8'h11);
        check("edge.err_none", {7'd0, pkt_err}, 8'h00);
        send_byte(8'h22);
        if (CHK_EN) send_byte(8'hA5 ^ 8'h11 ^ 8'h22);
        exp_a     = 8'h11;
        exp_b     = 8'h22;
        exp_alive = ~exp_alive;
        exp_cnt   = exp_cnt + 8'd1;
        check_outputs("edge.accepted", 1'b0);
        idle(1);

        // Noise then sync bytes used as data.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        send_pkt("sync_data_bad", 8'hA5, 8'hA5, 8'hF0);
        send_pkt("sync_data_good", 8'hA5, 8'hA5, 8'hA5);
        check("sync_data_good.speedB_val", speedB, 8'hA5);

        // Reset mid-packet.
        send_byte(8'hA5);
        send_byte(8'h10);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_a = 8'h00;
        exp_b = 8'h00;
        exp_alive = 1'b0;
        exp_cnt = 8'h00;
        check_outputs("mid_reset", 1'b0);
        send_pkt("after_reset", 8'h40, 8'hC0, 8'h25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
